// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encodings and width helpers.
package word_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP
    } state_e;

    // Counter widths never collapse to zero bits.
    function automatic int unsigned min1(input int unsigned x);
        return (x < 1) ? 1 : x;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-in handshake plus serial-out stream of the word serializer.
interface word_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             data;
    logic             data_valid;
    logic             last;

    modport master (
        output in_data, in_valid,
        input  in_ready, data, data_valid, last
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data, data_valid, last
    );
endinterface

// File: rtl/word_serializer.sv
// Serializes WIDTH-bit words one bit per cycle, with an optional idle gap after each word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    word_serializer_if.slave bus
);

    localparam int unsigned      CNT_W       = min1($clog2(WIDTH));
    localparam int unsigned      GAP_W       = min1($clog2(GAP + 1));
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(WIDTH - 2);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_e           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_data;
    logic             r_data_valid;
    logic             r_last;
    logic             r_in_ready;
    logic             w_accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // in_ready is only ever high in IDLE or on a GAP=0 last-bit cycle, so any accept is a load.
    assign w_accept = bus.in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_data       <= 1'b0;
            r_data_valid <= 1'b0;
            r_last       <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (w_accept) begin
            r_state      <= S_SHIFT;
            r_shift      <= advance(bus.in_data);
            r_cnt        <= '0;
            r_data       <= first_bit(bus.in_data);
            r_data_valid <= 1'b1;
            r_last       <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready   <= 1'b1;
                    r_data       <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_last       <= 1'b0;
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt        <= '0;
                        r_shift      <= '0;
                        r_data       <= 1'b0;
                        r_data_valid <= 1'b0;
                        r_last       <= 1'b0;
                        r_gap_cnt    <= '0;
                        if (GAP == 0) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= S_GAP;
                            r_in_ready <= 1'b0;
                        end
                    end else begin
                        r_cnt        <= r_cnt + CNT_W'(1);
                        r_data       <= first_bit(r_shift);
                        r_shift      <= advance(r_shift);
                        r_data_valid <= 1'b1;
                        r_last       <= (r_cnt == CNT_PRELAST);
                        r_in_ready   <= (GAP == 0) && (r_cnt == CNT_PRELAST);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_gap_cnt  <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.last       = r_last;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus randomized scoreboard runs.
module tb_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] sel;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       obs_ready, obs_data, obs_dv, obs_last;

    int n_cmp;
    int n_err;
    bit cfg_msb [3];
    int cfg_gap [3];

    word_serializer_if #(.WIDTH(8)) if0 ();
    word_serializer_if #(.WIDTH(8)) if1 ();
    word_serializer_if #(.WIDTH(8)) if2 ();

    word_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    word_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    word_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.in_data  = drv_data;
    assign if1.in_data  = drv_data;
    assign if2.in_data  = drv_data;
    assign if0.in_valid = drv_valid && (sel == 2'd0);
    assign if1.in_valid = drv_valid && (sel == 2'd1);
    assign if2.in_valid = drv_valid && (sel == 2'd2);

    always_comb begin
        obs_ready = 1'b0;
        obs_data  = 1'b0;
        obs_dv    = 1'b0;
        obs_last  = 1'b0;
        case (sel)
            2'd0: begin obs_ready = if0.in_ready; obs_data = if0.data; obs_dv = if0.data_valid; obs_last = if0.last; end
            2'd1: begin obs_ready = if1.in_ready; obs_data = if1.data; obs_dv = if1.data_valid; obs_last = if1.last; end
            2'd2: begin obs_ready = if2.in_ready; obs_data = if2.data; obs_dv = if2.data_valid; obs_last = if2.last; end
            default: ;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1; sel = 2'd0; drv_data = 8'hFF; drv_valid = 1'b1;
        repeat (3) cyc();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s); #1;
            got = {obs_ready, obs_data, obs_dv, obs_last};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_err++; $display("FAIL reset_hold dut%0d: got %b expected 0000", s, got);
            end
        end
        sel = 2'd0; rst = 1'b0; drv_valid = 1'b0;
        cyc();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s); #1;
            got = {obs_ready, obs_data, obs_dv, obs_last};
            n_cmp++;
            if (got !== 4'b1000) begin
                n_err++; $display("FAIL reset_release dut%0d: got %b expected 1000", s, got);
            end
        end
        sel = 2'd0;
        cyc();
    endtask

    task automatic send_one(input int s, input logic [7:0] w);
        logic [3:0] got, exp;
        sel = 2'(s); drv_data = w; #1;
        n_cmp++;
        if (obs_ready !== 1'b1) begin
            n_err++; $display("FAIL idle_ready dut%0d: got %b expected 1", s, obs_ready);
        end
        drv_valid = 1'b1;
        cyc();
        drv_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = {obs_dv, obs_data, obs_last, obs_ready};
            exp = {1'b1, exp_bit(w, i, cfg_msb[s]), i == 7, (i == 7) && (cfg_gap[s] == 0)};
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL word %h dut%0d bit%0d {dv,d,last,rdy}: got %b expected %b", w, s, i, got, exp);
            end
            cyc();
        end
        for (int g = 0; g < cfg_gap[s]; g++) begin
            got = {obs_dv, obs_data, obs_last, obs_ready};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_err++; $display("FAIL gap dut%0d cycle%0d: got %b expected 0000", s, g, got);
            end
            cyc();
        end
        got = {obs_dv, obs_data, obs_last, obs_ready};
        n_cmp++;
        if (got !== 4'b0001) begin
            n_err++; $display("FAIL return_idle dut%0d: got %b expected 0001", s, got);
        end
    endtask

    task automatic test_msb_first();
        send_one(0, 8'hA5);
        send_one(0, 8'h80);
    endtask

    task automatic test_lsb_first();
        send_one(1, 8'hA5);
        send_one(1, 8'h01);
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        logic [7:0] w;
        sel = 2'd0; drv_data = 8'hA5; drv_valid = 1'b1;
        cyc();
        drv_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            w   = (i < 8) ? 8'hA5 : 8'h3C;
            got = {obs_dv, obs_data, obs_last, obs_ready};
            exp = {1'b1, exp_bit(w, i % 8, 1'b1), (i % 8) == 7, (i % 8) == 7};
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL back_to_back cycle%0d {dv,d,last,rdy}: got %b expected %b", i, got, exp);
            end
            if (i == 8) drv_valid = 1'b0;
            cyc();
        end
        got = {obs_dv, obs_data, obs_last, obs_ready};
        n_cmp++;
        if (got !== 4'b0001) begin
            n_err++; $display("FAIL back_to_back_end: got %b expected 0001", got);
        end
    endtask

    task automatic test_gap();
        logic [3:0] got, exp;
        logic [7:0] words [2];
        int wi, ph;
        words[0] = 8'($urandom); words[1] = 8'($urandom);
        sel = 2'd2; drv_data = words[0]; drv_valid = 1'b1;
        cyc();
        drv_data = words[1];
        // Each word: 8 data cycles, GAP dead cycles, one ready IDLE cycle.
        for (int t = 0; t < 22; t++) begin
            wi = t / 11; ph = t % 11;
            if (ph < 8)       exp = {1'b1, exp_bit(words[wi], ph, 1'b1), ph == 7, 1'b0};
            else if (ph < 10) exp = 4'b0000;
            else              exp = 4'b0001;
            got = {obs_dv, obs_data, obs_last, obs_ready};
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL gap_sched t%0d {dv,d,last,rdy}: got %b expected %b", t, got, exp);
            end
            if (t == 11) drv_valid = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] got;
        sel = 2'd0; drv_data = 8'hFF; drv_valid = 1'b1;
        cyc();
        drv_valid = 1'b0;
        cyc(); cyc();
        got = {obs_dv, obs_data, obs_last, obs_ready};
        n_cmp++;
        if (got !== 4'b1100) begin
            n_err++; $display("FAIL midword_bit3: got %b expected 1100", got);
        end
        rst = 1'b1;
        cyc();
        got = {obs_dv, obs_data, obs_last, obs_ready};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++; $display("FAIL midword_reset: got %b expected 0000", got);
        end
        rst = 1'b0;
        cyc();
        got = {obs_dv, obs_data, obs_last, obs_ready};
        n_cmp++;
        if (got !== 4'b0001) begin
            n_err++; $display("FAIL midword_release: got %b expected 0001", got);
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_cmp++;
            if (obs_dv !== 1'b0 || obs_data !== 1'b0) begin
                n_err++; $display("FAIL midword_leak cycle%0d: got dv=%b d=%b expected 0 0", i, obs_dv, obs_data);
            end
        end
    endtask

    task automatic test_random(input int s, input int ncyc);
        logic [7:0] sent [$];
        logic [7:0] acc, exp_w;
        logic       accepted;
        int         nb;
        int         n_words;
        nb = 0; n_words = 0; acc = '0;
        sel = 2'(s); drv_valid = 1'b0;
        for (int c = 0; c < ncyc + 30; c++) begin
            if (!drv_valid && c < ncyc && (c < 20 || $urandom_range(0, 3) != 0)) begin
                drv_data = 8'($urandom); drv_valid = 1'b1;
            end
            accepted = drv_valid && obs_ready;
            if (accepted) sent.push_back(drv_data);
            cyc();
            if (accepted) drv_valid = 1'b0;
            if (obs_dv) begin
                acc = cfg_msb[s] ? {acc[6:0], obs_data} : {obs_data, acc[7:1]};
                nb++;
                n_cmp++;
                if ({obs_last, obs_ready} !== {nb == 8, (nb == 8) && (cfg_gap[s] == 0)}) begin
                    n_err++; $display("FAIL rand dut%0d bit%0d {last,rdy}: got %b%b expected %b%b", s, nb,
                                      obs_last, obs_ready, nb == 8, (nb == 8) && (cfg_gap[s] == 0));
                end
                if (nb == 8) begin
                    n_cmp++;
                    if (sent.size() == 0) begin
                        n_err++; $display("FAIL rand dut%0d word: got %h expected none pending", s, acc);
                    end else begin
                        exp_w = sent.pop_front();
                        if (acc !== exp_w) begin
                            n_err++; $display("FAIL rand dut%0d word%0d: got %h expected %h", s, n_words, acc, exp_w);
                        end
                    end
                    n_words++;
                    nb = 0;
                end
            end else begin
                n_cmp++;
                if (obs_data !== 1'b0 || obs_last !== 1'b0 || nb != 0) begin
                    n_err++; $display("FAIL rand dut%0d idle: got d=%b last=%b partial=%0d expected 0 0 0",
                                      s, obs_data, obs_last, nb);
                end
            end
        end
        n_cmp++;
        if (sent.size() != 0 || n_words == 0) begin
            n_err++; $display("FAIL rand dut%0d drain: got %0d unsent, %0d sent words expected 0 unsent, >0 sent",
                              s, sent.size(), n_words);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        cfg_msb = '{1'b1, 1'b0, 1'b1};
        cfg_gap = '{0, 0, 2};
        rst = 1'b1; sel = 2'd0; drv_data = '0; drv_valid = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_gap();
        test_reset_midword();
        test_random(0, 200);
        test_random(1, 200);
        test_random(2, 200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: parallel word width in bits, minimum 2.
REQ-002 The block SHALL have parameter GAP, default 0: number of forced idle cycles after each word.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 = send bit WIDTH-1 first, 0 = send bit 0 first.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the parallel word to send.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data holds a word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port data, output, 1 bit: the serial bit stream.
REQ-010 The block SHALL have port data_valid, output, 1 bit: data carries a word bit this cycle.
REQ-011 The block SHALL have port last, output, 1 bit: data carries the final bit of the word.

Function
REQ-012 A word SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_data is sampled only on that cycle.
REQ-013 The state machine SHALL have three states: IDLE, SHIFT and GAP.
REQ-014 In IDLE, in_ready SHALL be 1 and data, data_valid and last SHALL be 0.
REQ-015 On accept in IDLE:
- the word loads into the shift register;
- the bit counter clears to 0;
- the state moves to SHIFT.
REQ-016 The first bit of an accepted word SHALL appear on data on the cycle after accept (latency 1 cycle).
REQ-017 In SHIFT:
- data_valid SHALL be 1;
- data SHALL be the current bit, in the order set by MSB_FIRST;
- the counter increments by 1 per cycle from 0 to WIDTH-1;
- exactly WIDTH valid bits are sent per word.
REQ-018 last SHALL be 1 only on the SHIFT cycle where the counter equals WIDTH-1.
REQ-019 In SHIFT, in_ready SHALL be 0 except on the last-bit cycle when GAP equals 0, where in_ready is 1.
REQ-020 With GAP equal to 0, an accept on the last-bit cycle SHALL load the next word, and its first bit SHALL follow with no bubble.
REQ-021 After the last bit with GAP equal to 0 and no accept, the state SHALL move to IDLE.
REQ-022 After the last bit with GAP greater than 0:
- the state moves to GAP for exactly GAP cycles;
- in GAP, in_ready, data, data_valid and last are all 0;
- the state then moves to IDLE.
REQ-023 If in_valid is held while in_ready is 0, the word SHALL NOT be lost: it is accepted on the first cycle in_ready is 1.
REQ-024 data SHALL be 0 whenever data_valid is 0.
REQ-025 data, data_valid and last SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-026 While rst is 1:
- the state is IDLE;
- the counter and shift register are 0;
- data, data_valid, last and in_ready are all 0.
REQ-027 in_ready SHALL rise to 1 on the first cycle after rst falls.
REQ-028 Reset during SHIFT or GAP SHALL discard the word in flight, and no remaining bits of it SHALL ever be emitted.
REQ-029 A handshake on a cycle where rst is 1 SHALL be ignored.

Structure
REQ-030 The state encodings (IDLE, SHIFT, GAP) SHALL be defined as constants in the shared package so the bench and other serial blocks can decode them.
REQ-031 The counter width SHALL be $clog2(WIDTH) and the GAP counter width SHALL be $clog2(GAP+1), with a minimum of 1 bit each.
REQ-032 The block SHALL be a single module with no sub-modules; the shift register, bit counter and gap counter are inline.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- WIDTH=8, MSB_FIRST=1, GAP=0: accept 0xA5 -> data = 1,0,1,0,0,1,0,1 on the next 8 cycles, data_valid=1 throughout, last=1 on cycle 8 only.
- MSB_FIRST=0: accept 0xA5 -> data = 1,0,1,0,0,1,0,1 (LSB first); accept 0x01 -> 1 then seven 0s.
- GAP=0, in_valid held with 0xA5 then 0x3C -> 16 contiguous data_valid cycles, in_ready high only on each last-bit cycle, second word bits = 0,0,1,1,1,1,0,0.
- GAP=2, two words back-to-back -> exactly 2 cycles with data_valid=0 and in_ready=0 between words, then 1 IDLE cycle with in_ready=1 before the second accept.
- rst asserted after 3 bits of 0xFF -> data_valid=0 and data=0 on the next cycle, in_ready=1 one cycle after rst falls, and no remaining 1s appear.
- in_valid held for 20 cycles while busy -> each word sent exactly once, and the bench scoreboard matches the serial output, reassembled, against the input words.
